// File: rtl/button_input_port.sv
// button_input_port: synchronises, debounces and edge-detects user buttons; latches presses
// as pending interrupt flags and exposes levels, pending bits and a press counter via a read port.
module button_input_port #(
  parameter int NUM_IN    = 4,
  parameter int DB_CYCLES = 100000,
  parameter int CNT_W     = 17
) (
  input  logic              rclk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] btn_in,
  input  logic              rd_en,
  input  logic [1:0]        rd_addr,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic [NUM_IN-1:0] db_level,
  output logic [NUM_IN-1:0] press_pulse,
  output logic              irq
);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DB_CYCLES - 1);
  logic [NUM_IN-1:0] s1_q, s2_q, db_q, db_d, pulse_q, pulse_d, pend_q, pend_d, rise, clr;
  logic [CNT_W-1:0]  cnt_q [NUM_IN];
  logic [CNT_W-1:0]  cnt_d [NUM_IN];
  logic [15:0]       press_count_q, press_count_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [4:0]        pop;
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_d[i] = (s2_q[i] == db_q[i] || cnt_q[i] == TERM) ? '0 : cnt_q[i] + 1'b1;
      db_d[i]  = (s2_q[i] != db_q[i] && cnt_q[i] == TERM) ? s2_q[i] : db_q[i];
    end
  end
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_IN; i++) pop = pop + 5'(rise[i]);
  end
  // a press accepted on the same edge as a read-clear survives: set wins over clear
  always_comb begin
    rise          = db_d & ~db_q;
    pulse_d       = rise;
    clr           = (rd_en && rd_addr == 2'd1) ? pend_q : '0;
    pend_d        = (pend_q & ~clr) | rise;
    press_count_d = press_count_q + 16'(pop);
    rd_valid_d    = rd_en;
    rd_data_d     = !rd_en            ? rd_data_q :
                    rd_addr == 2'd0   ? 32'(db_q) :
                    rd_addr == 2'd1   ? 32'(pend_q) :
                    rd_addr == 2'd2   ? {16'b0, press_count_q} : 32'h0;
  end
  always_ff @(posedge rclk) begin
    if (rst) begin
      s1_q          <= '0;
      s2_q          <= '0;
      db_q          <= '0;
      pulse_q       <= '0;
      pend_q        <= '0;
      cnt_q         <= '{default: '0};
      press_count_q <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      s1_q          <= btn_in;
      s2_q          <= s1_q;
      db_q          <= db_d;
      pulse_q       <= pulse_d;
      pend_q        <= pend_d;
      cnt_q         <= cnt_d;
      press_count_q <= press_count_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
    end
  end
  assign db_level    = db_q;
  assign press_pulse = pulse_q;
  assign irq         = |pend_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
endmodule

// File: tb/tb_button_input_port.sv
// tb_button_input_port: directed stimulus against a sliding-window debounce model of the button port.
module tb_button_input_port;
  localparam int N = 4, DB = 4;
  logic rclk = 1'b0, rst = 1'b1, rd_en = 1'b0;
  logic [1:0] rd_addr = 2'd0;
  logic [N-1:0] btn_in = '0;
  logic [31:0] rd_data;
  logic rd_valid, irq;
  logic [N-1:0] db_level, press_pulse;
  int checks = 0, errors = 0;
  always #5 rclk = ~rclk;
  button_input_port #(.NUM_IN(N), .DB_CYCLES(DB), .CNT_W(3)) dut (
    .rclk(rclk), .rst(rst), .btn_in(btn_in), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .db_level(db_level),
    .press_pulse(press_pulse), .irq(irq)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask
  // A level is accepted once the last DB synchronised samples all disagree with it.
  logic [N-1:0] dly[$], seen[$];
  logic [N-1:0] m_lvl, m_new, m_rise, m_pulse, m_pend, m_clr;
  logic [15:0] m_cnt;
  logic [31:0] m_rdata;
  logic m_rvalid, armed = 1'b0;
  always @(posedge rclk) begin
    bit ad;
    if (rst) begin
      dly.delete(); dly.push_back('0); dly.push_back('0);
      seen.delete();
      m_lvl = '0; m_pulse = '0; m_pend = '0; m_cnt = '0; m_rdata = '0; m_rvalid = 1'b0;
      armed = 1'b1;
    end else begin
      seen.push_back(dly.pop_front());
      dly.push_back(btn_in);
      if (seen.size() > DB) void'(seen.pop_front());
      for (int i = 0; i < N; i++) begin
        ad = (seen.size() == DB);
        foreach (seen[k]) if (seen[k][i] == m_lvl[i]) ad = 1'b0;
        m_new[i] = ad ? ~m_lvl[i] : m_lvl[i];
      end
      m_rise = m_new & ~m_lvl;
      m_clr = (rd_en && rd_addr == 2'd1) ? m_pend : '0;
      if (rd_en)
        m_rdata = rd_addr == 2'd0 ? 32'(m_lvl) : rd_addr == 2'd1 ? 32'(m_pend) :
                  rd_addr == 2'd2 ? 32'(m_cnt) : 32'h0;
      m_rvalid = rd_en;
      m_pend = (m_pend & ~m_clr) | m_rise;
      m_cnt = m_cnt + 16'($countones(m_rise));
      m_pulse = m_rise;
      m_lvl = m_new;
    end
  end
  always @(negedge rclk) if (armed) begin
    chk("m_db_level", db_level, m_lvl);
    chk("m_press_pulse", press_pulse, m_pulse);
    chk("m_irq", irq, |m_pend);
    chk("m_rd_valid", rd_valid, m_rvalid);
    chk("m_rd_data", rd_data, m_rdata);
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge rclk);
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = a;
    @(negedge rclk);
    rd_en = 1'b0;
    chk("rd_valid_pulse", rd_valid, 1);
    d = rd_data;
  endtask
  initial begin
    logic [31:0] d;
    int np;
    @(negedge rclk);
    rst = 1'b1; btn_in = 4'hF; rd_en = 1'b1; rd_addr = 2'd1;
    cyc(2);
    chk("rst_db", db_level, 0); chk("rst_pulse", press_pulse, 0); chk("rst_irq", irq, 0);
    chk("rst_rd_valid", rd_valid, 0); chk("rst_rd_data", rd_data, 0);
    rd_en = 1'b0; rst = 1'b0; np = 0;
    repeat (10) begin cyc(1); if (press_pulse == 4'hF) np++; end
    chk("rst_press_once", np, 1); chk("rst_db_f", db_level, 4'hF); chk("rst_irq_set", irq, 1);
    rd(2'd2, d); chk("rst_count", d, 4);
    rd(2'd1, d); chk("rst_pend", d, 4'hF); chk("pend_cleared_irq", irq, 0);
    btn_in = '0; cyc(10);
    rd(2'd2, d); chk("release_no_count", d, 4); chk("release_no_irq", irq, 0);
    btn_in = 4'h1; cyc(5);
    chk("press_pre_accept", db_level[0], 0);
    cyc(1);
    chk("press_accept", db_level, 4'h1); chk("press_pulse_hi", press_pulse, 4'h1);
    cyc(1);
    chk("press_pulse_lo", press_pulse, 0); chk("press_irq", irq, 1);
    rd(2'd1, d); chk("rdclr_first", d, 1); chk("rdclr_irq", irq, 0);
    rd(2'd1, d); chk("rdclr_second", d, 0);
    rd(2'd0, d); chk("level_read", d, 1);
    repeat (10) begin btn_in = 4'h3; cyc(3); btn_in = 4'h1; cyc(1); end
    cyc(10);
    chk("bounce_db", db_level, 4'h1); chk("bounce_irq", irq, 0);
    rd(2'd2, d); chk("bounce_count", d, 5);
    btn_in = '0; cyc(10);
    btn_in = 4'h5; cyc(10);
    chk("simul_irq", irq, 1);
    rd(2'd2, d); chk("simul_count", d, 7);
    btn_in = 4'hD; cyc(5);
    rd(2'd1, d); chk("collide_read", d, 5);
    rd(2'd1, d); chk("collide_after", d, 8);
    rd(2'd2, d); chk("collide_count", d, 8);
    btn_in = '0; cyc(10);
    force dut.press_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    cyc(1);
    release dut.press_count_q;
    rd(2'd2, d); chk("preload", d, 32'hFFFF);
    btn_in = 4'h1; cyc(8);
    rd(2'd2, d); chk("wrap", d, 0);
    btn_in = 4'h3; rd_en = 1'b1; rd_addr = 2'd0; rst = 1'b1;
    cyc(1);
    rd_en = 1'b0; rst = 1'b0;
    chk("midrst_rd_dropped", rd_valid, 0); chk("midrst_db", db_level, 0);
    np = 0;
    repeat (10) begin cyc(1); if (press_pulse == 4'h3) np++; end
    chk("midrst_fresh_press", np, 1);
    rd(2'd2, d); chk("midrst_count", d, 2);
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
